hamming_enc: RTL and testbench

Clocked Hamming(7,4) encoder, the transmit-side counterpart of the 7-bit single-error-correcting decoder.
- Accepts 4-bit data words over a valid/ready handshake and produces 7-bit codewords in the same bit ordering the decoder expects.
- Buffers codewords in a small FIFO.
- Provides a per-word single-bit error-injection hook for exercising the decoder.
- Keeps sent-word and injected-error counters.

---
 rtl/hamming_pkg.sv | 36 +++
 rtl/ecc_fifo.sv | 58 +++++
 rtl/hamming_enc.sv | 61 ++++++
 tb/tb_hamming_enc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit positions, types, encoder and syndrome.
package hamming_pkg;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int D0_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int D1_IDX = 4;
  localparam int D2_IDX = 5;
  localparam int D3_IDX = 6;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] codeword_t;

  function automatic codeword_t encode(input nibble_t d);
    codeword_t c;
    c[D0_IDX] = d[0];
    c[D1_IDX] = d[1];
    c[D2_IDX] = d[2];
    c[D3_IDX] = d[3];
    c[P1_IDX] = d[0] ^ d[1] ^ d[3];
    c[P2_IDX] = d[0] ^ d[2] ^ d[3];
    c[P4_IDX] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // Syndrome value equals the 1-based position of a single flipped bit.
  function automatic logic [2:0] syndrome(input codeword_t c);
    logic [2:0] s;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    return s;
  endfunction

endpackage

// File: rtl/ecc_fifo.sv
// Synchronous valid/ready FIFO; head reads zero while empty, no write-to-read bypass.
module ecc_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign wr_ready = rst_n && !full;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hamming_enc.sv
// Hamming(7,4) encoder with per-word single-bit error injection, output FIFO and counters.
module hamming_enc
  import hamming_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_data,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] inj_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic      inj_hit;
  codeword_t flip;
  codeword_t code;
  logic      push;
  logic      pop;

  // Position 0 means "no flip", so the shift only applies when a real position is given.
  assign inj_hit = inj_en && (inj_pos != 3'd0);
  assign flip    = inj_hit ? (codeword_t'(1) << (inj_pos - 3'd1)) : '0;
  assign code    = encode(in_data) ^ flip;
  assign push    = in_valid && in_ready;
  assign pop     = out_valid && out_ready;

  ecc_fifo #(
    .WIDTH (7),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (code),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
      inj_cnt  <= '0;
    end else begin
      if (pop)             word_cnt <= word_cnt + CNT_ONE;
      if (push && inj_hit) inj_cnt  <= inj_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hamming_enc.sv
// Directed bench for hamming_enc: vector table plus hand-written multi-cycle sequences.
module tb_hamming_enc;
  import hamming_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        inj_en;
  logic [2:0]  inj_pos;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [15:0] word_cnt;
  logic [15:0] inj_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_words = 0;
  int exp_inj = 0;

  hamming_enc #(.DEPTH(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .inj_en    (inj_en),
    .inj_pos   (inj_pos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .word_cnt  (word_cnt),
    .inj_cnt   (inj_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       en;
    logic [2:0] pos;
    logic [6:0] code;
    logic [2:0] syn;
    logic       hit;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference: parity bit at position p covers every position q with (q & p) != 0.
  function automatic logic [6:0] ref_encode(input logic [3:0] d);
    logic [6:0] c;
    int dpos [4];
    dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
    c = '0;
    for (int k = 0; k < 4; k++) c[dpos[k]-1] = d[k];
    for (int p = 1; p <= 4; p = p * 2)
      for (int q = 1; q <= 7; q++)
        if (((q & p) != 0) && (q != p)) c[p-1] = c[p-1] ^ c[q-1];
    return c;
  endfunction

  function automatic logic [3:0] ref_decode(input logic [6:0] c_in);
    logic [6:0] c;
    int s;
    c = c_in;
    s = 0;
    for (int q = 1; q <= 7; q++) if (c[q-1]) s = s ^ q;
    if (s != 0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{4'b1011, 1'b1, 3'd3, 7'h51, 3'd3, 1'b1};
    tbl[1] = '{4'b1011, 1'b1, 3'd0, 7'h55, 3'd0, 1'b0};
    tbl[2] = '{4'b1011, 1'b0, 3'd5, 7'h55, 3'd0, 1'b0};
    tbl[3] = '{4'h0,    1'b1, 3'd7, 7'h40, 3'd7, 1'b1};
    tbl[4] = '{4'hF,    1'b1, 3'd1, 7'h7E, 3'd1, 1'b1};
    tbl[5] = '{4'h6,    1'b0, 3'd0, 7'h33, 3'd0, 1'b0};
    tbl[6] = '{4'h8,    1'b1, 3'd4, 7'h43, 3'd4, 1'b1};
    tbl[7] = '{4'hA,    1'b0, 3'd2, 7'h52, 3'd0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_inj_cnt", inj_cnt, 0);
    rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1);

    // Single word, latency 1
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'b1011; out_ready = 1'b1;
    @(negedge clk);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 7'h55);
    in_valid = 1'b0;
    exp_words++;
    @(negedge clk);
    check("t1_word_cnt", word_cnt, exp_words);
    check("t1_empty", out_valid, 0);

    // Back-to-back stream
    begin
      logic [3:0] sd [3];
      logic [6:0] sc [3];
      sd[0] = 4'h0; sd[1] = 4'hF; sd[2] = 4'h1;
      sc[0] = 7'h00; sc[1] = 7'h7F; sc[2] = 7'h07;
      in_valid = 1'b1; in_data = sd[0];
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("t2_out_valid", out_valid, 1);
        check("t2_out_data", out_data, sc[i]);
        check("t2_in_ready", in_ready, 1);
        check("t2_syndrome", syndrome(out_data), 0);
        if (i < 2) in_data = sd[i+1];
        else in_valid = 1'b0;
      end
      exp_words += 3;
      @(negedge clk);
      check("t2_word_cnt", word_cnt, exp_words);
    end

    // Backpressure with DEPTH=2: third word held until space frees
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h2;
    check("t3_ready0", in_ready, 1);
    @(negedge clk);
    in_data = 4'h9;
    check("t3_ready1", in_ready, 1);
    check("t3_head_a", out_data, ref_encode(4'h2));
    @(negedge clk);
    in_data = 4'hC;
    check("t3_full", in_ready, 0);
    @(negedge clk);
    check("t3_still_full", in_ready, 0);
    check("t3_hold_a", out_data, ref_encode(4'h2));
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_ready_back", in_ready, 1);
    check("t3_head_b", out_data, ref_encode(4'h9));
    @(negedge clk);
    check("t3_head_c", out_data, ref_encode(4'hC));
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_drained", out_valid, 0);
    exp_words += 3;
    check("t3_word_cnt", word_cnt, exp_words);

    // Injection vector table
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = tbl[i].data; inj_en = tbl[i].en; inj_pos = tbl[i].pos;
      @(negedge clk);
      check("tbl_out_data", out_data, tbl[i].code);
      check("tbl_syndrome", syndrome(out_data), tbl[i].syn);
      in_valid = 1'b0;
      if (tbl[i].hit) exp_inj++;
      exp_words++;
      @(negedge clk);
      check("tbl_inj_cnt", inj_cnt, exp_inj);
    end
    check("tbl_word_cnt", word_cnt, exp_words);
    inj_en = 1'b0; inj_pos = '0;

    // Asynchronous reset with two words buffered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h3;
    @(negedge clk);
    in_data = 4'h5;
    @(negedge clk);
    in_valid = 1'b0;
    check("t5_full_before", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_word_cnt", word_cnt, 0);
    check("t5_inj_cnt", inj_cnt, 0);
    check("t5_in_ready", in_ready, 0);
    exp_words = 0; exp_inj = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 4'h6; out_ready = 1'b1;
    @(negedge clk);
    check("t5_post_valid", out_valid, 1);
    check("t5_post_data", out_data, 7'h33);
    in_valid = 1'b0;
    exp_words++;
    @(negedge clk);
    check("t5_post_cnt", word_cnt, exp_words);

    // Exhaustive nibble x position
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        logic [6:0] expc;
        expc = ref_encode(4'(d));
        if (p != 0) expc[p-1] = ~expc[p-1];
        in_valid = 1'b1; in_data = 4'(d); inj_en = 1'b1; inj_pos = 3'(p);
        @(negedge clk);
        check("ex_out_data", out_data, expc);
        check("ex_syndrome", syndrome(out_data), p);
        check("ex_decode", ref_decode(out_data), d);
        in_valid = 1'b0;
        if (p != 0) exp_inj++;
        exp_words++;
        @(negedge clk);
      end
    end
    check("ex_inj_cnt", inj_cnt, exp_inj);
    check("ex_word_cnt", word_cnt, exp_words);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
